// File: rtl/axi_writer_pkg.sv
// Shared types and constants for the AXI3 burst write master.
package axi_writer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    // AxSIZE encoding: log2 of the beat width in bytes.
    function automatic logic [2:0] size_enc(input int unsigned bytes);
        logic [2:0] enc;
        enc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bytes == (32'd1 << i)) enc = 3'(i);
        end
        return enc;
    endfunction

endpackage

// File: rtl/axi_burst_writer_if.sv
// AXI3 write-channel bundle (AW, W, B) between the burst writer and an HP port.
interface axi_burst_writer_if #(
    parameter int DATA_W = 64
);
    logic [31:0]         M_AXI_AWADDR;
    logic [3:0]          M_AXI_AWLEN;
    logic [2:0]          M_AXI_AWSIZE;
    logic [1:0]          M_AXI_AWBURST;
    logic                M_AXI_AWVALID;
    logic                M_AXI_AWREADY;
    logic [DATA_W-1:0]   M_AXI_WDATA;
    logic [DATA_W/8-1:0] M_AXI_WSTRB;
    logic                M_AXI_WLAST;
    logic                M_AXI_WVALID;
    logic                M_AXI_WREADY;
    logic [1:0]          M_AXI_BRESP;
    logic                M_AXI_BVALID;
    logic                M_AXI_BREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
    );

endinterface

// File: rtl/burst_len_fifo.sv
// Small synchronous FIFO carrying AWLEN values from the AW side to the W side.
module burst_len_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       ACLK,
    input  logic       ARESETN,
    input  logic       push,
    input  logic [3:0] din,
    input  logic       pop,
    output logic [3:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/axi_burst_writer.sv
// AXI3 write master: streams din into a contiguous region as boundary-aligned INCR bursts.
// state | meaning: IDLE waiting for config | RUN issuing AW/W | DRAIN waiting for final B responses
module axi_burst_writer
    import axi_writer_pkg::*;
#(
    parameter int DATA_W          = 64,
    parameter int BURST_BEATS     = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    axi_burst_writer_if.master   m_axi,
    input  logic                 CONFIG_VALID,
    output logic                 CONFIG_READY,
    input  logic [31:0]          CONFIG_START_ADDR,
    input  logic [31:0]          CONFIG_NBYTES,
    input  logic [DATA_W-1:0]    din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 DONE,
    output logic                 ERROR
);
    localparam int         BEAT_BYTES = DATA_W / 8;
    localparam int         BSH        = $clog2(BEAT_BYTES);
    localparam logic [2:0] AW_SIZE    = size_enc(BEAT_BYTES);

    state_t      state_q, state_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [3:0]  awlen_q, awlen_d;
    logic [31:0] nxt_addr_q, nxt_addr_d;
    logic [31:0] aw_beats_q, aw_beats_d;
    logic [3:0]  outst_q, outst_d;
    logic        w_active_q, w_active_d;
    logic [3:0]  w_cnt_q, w_cnt_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        aw_hs, w_hs, accept, load;
    logic [31:0] cfg_addr, cfg_beats, src_addr, src_beats;
    logic [31:0] beat_off, room, burst_len;
    logic        fifo_pop, fifo_full, fifo_empty;
    logic [3:0]  fifo_dout;

    assign aw_hs     = awvalid_q && m_axi.M_AXI_AWREADY;
    assign w_hs      = w_active_q && din_valid && m_axi.M_AXI_WREADY;
    assign accept    = CONFIG_VALID && (state_q == IDLE);
    assign cfg_addr  = CONFIG_START_ADDR & ~32'(BEAT_BYTES - 1);
    assign cfg_beats = CONFIG_NBYTES >> BSH;

    // The first burst is computed straight from the config so AWVALID rises the cycle after acceptance.
    assign src_addr  = (state_q == IDLE) ? cfg_addr  : nxt_addr_q;
    assign src_beats = (state_q == IDLE) ? cfg_beats : aw_beats_q;
    assign beat_off  = (src_addr >> BSH) & 32'(BURST_BEATS - 1);
    assign room      = 32'(BURST_BEATS) - beat_off;
    assign burst_len = (src_beats < room) ? src_beats : room;

    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        nxt_addr_d = nxt_addr_q;
        aw_beats_d = aw_beats_q;
        w_active_d = w_active_q;
        w_cnt_d    = w_cnt_q;
        done_d     = 1'b0;
        error_d    = error_q;
        outst_d    = outst_q + {3'b000, aw_hs} - {3'b000, m_axi.M_AXI_BVALID};

        // AW slot reloads only against the post-update outstanding count, so AWVALID never rises at the limit.
        load = (accept && (cfg_beats != '0)) ||
               ((state_q == RUN) && (!awvalid_q || aw_hs) && (aw_beats_q != '0) &&
                (outst_d < 4'(MAX_OUTSTANDING)) && !fifo_full);

        if (aw_hs) awvalid_d = 1'b0;
        if (load) begin
            awvalid_d  = 1'b1;
            awaddr_d   = src_addr;
            awlen_d    = 4'(burst_len - 32'd1);
            nxt_addr_d = src_addr + (burst_len << BSH);
            aw_beats_d = src_beats - burst_len;
        end

        fifo_pop = !fifo_empty && (!w_active_q || (w_hs && (w_cnt_q == '0)));
        if (w_hs) begin
            if (w_cnt_q == '0) w_active_d = 1'b0;
            else               w_cnt_d    = w_cnt_q - 4'd1;
        end
        if (fifo_pop) begin
            w_active_d = 1'b1;
            w_cnt_d    = fifo_dout;
        end

        if (m_axi.M_AXI_BVALID && (m_axi.M_AXI_BRESP != RESP_OKAY)) error_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    error_d = 1'b0;
                    if (cfg_beats == '0) done_d  = 1'b1;
                    else                 state_d = RUN;
                end
            end
            RUN: begin
                if ((aw_beats_q == '0) && !awvalid_q && fifo_empty && !w_active_q)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (outst_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            awvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            nxt_addr_q <= '0;
            aw_beats_q <= '0;
            outst_q    <= '0;
            w_active_q <= 1'b0;
            w_cnt_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            awvalid_q  <= awvalid_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            nxt_addr_q <= nxt_addr_d;
            aw_beats_q <= aw_beats_d;
            outst_q    <= outst_d;
            w_active_q <= w_active_d;
            w_cnt_q    <= w_cnt_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    burst_len_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_len_fifo (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .push    (aw_hs),
        .din     (awlen_q),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_axi.M_AXI_AWADDR  = awaddr_q;
    assign m_axi.M_AXI_AWLEN   = awlen_q;
    assign m_axi.M_AXI_AWSIZE  = AW_SIZE;
    assign m_axi.M_AXI_AWBURST = AXI_BURST_INCR;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = din;
    assign m_axi.M_AXI_WSTRB   = '1;
    assign m_axi.M_AXI_WLAST   = w_active_q && (w_cnt_q == '0);
    assign m_axi.M_AXI_WVALID  = w_active_q && din_valid;
    assign m_axi.M_AXI_BREADY  = 1'b1;
    assign din_ready           = w_active_q && m_axi.M_AXI_WREADY;
    assign CONFIG_READY        = (state_q == IDLE);
    assign DONE                = done_q;
    assign ERROR               = error_q;

endmodule

// File: tb/tb_axi_burst_writer.sv
// Directed bench for axi_burst_writer with a simple always-ready slave and B-response model.
module tb_axi_burst_writer;
    localparam int DATA_W = 64;
    localparam int MAXO   = 2;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    axi_burst_writer_if #(.DATA_W(DATA_W)) bus ();

    logic              CONFIG_VALID = 1'b0;
    logic              CONFIG_READY;
    logic [31:0]       CONFIG_START_ADDR = '0;
    logic [31:0]       CONFIG_NBYTES = '0;
    logic [DATA_W-1:0] din;
    logic              din_valid = 1'b0;
    logic              din_ready;
    logic              DONE;
    logic              ERROR;

    axi_burst_writer #(
        .DATA_W          (DATA_W),
        .BURST_BEATS     (16),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .ACLK              (ACLK),
        .ARESETN           (ARESETN),
        .m_axi             (bus),
        .CONFIG_VALID      (CONFIG_VALID),
        .CONFIG_READY      (CONFIG_READY),
        .CONFIG_START_ADDR (CONFIG_START_ADDR),
        .CONFIG_NBYTES     (CONFIG_NBYTES),
        .din               (din),
        .din_valid         (din_valid),
        .din_ready         (din_ready),
        .DONE              (DONE),
        .ERROR             (ERROR)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // monitor state, written only by the monitor process
    int          aw_n = 0, w_n = 0, wl_n = 0, done_n = 0;
    int          burst_idx = 0, bib = 0, out_tb = 0;
    int          order_err = 0, wlast_err = 0, data_err = 0, ovf_err = 0;
    logic [31:0] aw_addr_a [64];
    logic [3:0]  aw_len_a  [64];
    int          wl_pos    [64];

    // slave control, written only by the main process
    logic b_en = 1'b1;
    int   err_idx = -1;
    int   b_issued = 0;

    initial forever begin
        @(negedge ACLK);
        if (!ARESETN) begin
            out_tb    = 0;
            burst_idx = aw_n;
            bib       = 0;
        end else begin
            if (bus.M_AXI_AWVALID && out_tb >= MAXO) ovf_err++;
            if (DONE) done_n++;
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
                if (burst_idx >= aw_n) order_err++;
                if (bus.M_AXI_WDATA !== {32'hD0D0_0000, 32'(w_n)}) data_err++;
                if (bus.M_AXI_WLAST !== (4'(bib) == aw_len_a[burst_idx % 64])) wlast_err++;
                w_n++;
                if (bus.M_AXI_WLAST) begin
                    wl_pos[wl_n % 64] = w_n;
                    wl_n++;
                    burst_idx++;
                    bib = 0;
                end else begin
                    bib++;
                end
            end
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
                aw_addr_a[aw_n % 64] = bus.M_AXI_AWADDR;
                aw_len_a[aw_n % 64]  = bus.M_AXI_AWLEN;
                aw_n++;
                out_tb++;
            end
            if (bus.M_AXI_BVALID) out_tb--;
        end
    end

    // one B response per completed burst, one per cycle
    initial begin
        bus.M_AXI_BVALID = 1'b0;
        bus.M_AXI_BRESP  = 2'b00;
        forever begin
            @(posedge ACLK);
            #1;
            if (!ARESETN) begin
                b_issued         = wl_n;
                bus.M_AXI_BVALID = 1'b0;
            end else if (b_en && b_issued < wl_n) begin
                bus.M_AXI_BVALID = 1'b1;
                bus.M_AXI_BRESP  = (b_issued == err_idx) ? 2'b10 : 2'b00;
                b_issued++;
            end else begin
                bus.M_AXI_BVALID = 1'b0;
                bus.M_AXI_BRESP  = 2'b00;
            end
        end
    end

    initial begin
        din = '0;
        forever begin
            @(posedge ACLK);
            #1;
            din = {32'hD0D0_0000, 32'(w_n)};
        end
    end

    task automatic cfg(input logic [31:0] a, input logic [31:0] n);
        @(posedge ACLK);
        #1;
        CONFIG_START_ADDR = a;
        CONFIG_NBYTES     = n;
        CONFIG_VALID      = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge ACLK);
            if (CONFIG_READY) break;
        end
        chk("cfg_ready", CONFIG_READY, 1);
        @(posedge ACLK);
        #1;
        CONFIG_VALID = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge ACLK);
            if (DONE) break;
        end
        chk(tag, DONE, 1);
        @(negedge ACLK);
        chk({tag, "_one_cycle"}, DONE, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_awvalid"}, bus.M_AXI_AWVALID, 0);
        chk({tag, "_wvalid"},  bus.M_AXI_WVALID, 0);
        chk({tag, "_wlast"},   bus.M_AXI_WLAST, 0);
        chk({tag, "_done"},    DONE, 0);
        chk({tag, "_error"},   ERROR, 0);
        chk({tag, "_din_rdy"}, din_ready, 0);
        chk({tag, "_awaddr"},  bus.M_AXI_AWADDR, 0);
        chk({tag, "_awlen"},   bus.M_AXI_AWLEN, 0);
        chk({tag, "_cfg_rdy"}, CONFIG_READY, 1);
        chk({tag, "_awsize"},  bus.M_AXI_AWSIZE, 3);
        chk({tag, "_awburst"}, bus.M_AXI_AWBURST, 1);
        chk({tag, "_wstrb"},   bus.M_AXI_WSTRB, 32'hFF);
        chk({tag, "_bready"},  bus.M_AXI_BREADY, 1);
    endtask

    int ab, wb, lb, db, bb;

    task automatic snap();
        ab = aw_n; wb = w_n; lb = wl_n; db = done_n; bb = b_issued;
    endtask

    initial begin
        bus.M_AXI_AWREADY = 1'b1;
        bus.M_AXI_WREADY  = 1'b1;
        din_valid         = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk_reset_vals("por");
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        // two aligned 16-beat bursts
        snap();
        cfg(32'h1000, 256);
        chk("t1_first_awvalid", bus.M_AXI_AWVALID, 1);
        chk("t1_first_awaddr", bus.M_AXI_AWADDR, 32'h1000);
        chk("t1_first_awlen", bus.M_AXI_AWLEN, 15);
        wait_done("t1_done", 400);
        chk("t1_aw_count", aw_n - ab, 2);
        chk("t1_aw0_addr", aw_addr_a[ab % 64], 32'h1000);
        chk("t1_aw1_addr", aw_addr_a[(ab + 1) % 64], 32'h1080);
        chk("t1_aw1_len", aw_len_a[(ab + 1) % 64], 15);
        chk("t1_w_beats", w_n - wb, 32);
        chk("t1_wlast0_pos", wl_pos[lb % 64] - wb, 16);
        chk("t1_wlast1_pos", wl_pos[(lb + 1) % 64] - wb, 32);
        chk("t1_done_count", done_n - db, 1);
        chk("t1_error", ERROR, 0);

        // unaligned start, truncated byte count: 10 + 15 beats
        snap();
        cfg(32'h1030, 200);
        wait_done("t2_done", 400);
        chk("t2_aw_count", aw_n - ab, 2);
        chk("t2_aw0_addr", aw_addr_a[ab % 64], 32'h1030);
        chk("t2_aw0_len", aw_len_a[ab % 64], 9);
        chk("t2_aw1_addr", aw_addr_a[(ab + 1) % 64], 32'h1080);
        chk("t2_aw1_len", aw_len_a[(ab + 1) % 64], 14);
        chk("t2_w_beats", w_n - wb, 25);
        chk("t2_wlast0_pos", wl_pos[lb % 64] - wb, 10);
        chk("t2_wlast1_pos", wl_pos[(lb + 1) % 64] - wb, 25);
        chk("t2_b_count", b_issued - bb, 2);

        // outstanding limit with B withheld
        snap();
        b_en = 1'b0;
        cfg(32'h2000, 1024);
        repeat (80) @(negedge ACLK);
        chk("t3_aw_held_count", aw_n - ab, 2);
        chk("t3_awvalid_held", bus.M_AXI_AWVALID, 0);
        b_en = 1'b1;
        wait_done("t3_done", 1500);
        chk("t3_aw_count", aw_n - ab, 8);
        chk("t3_w_beats", w_n - wb, 128);
        chk("t3_wlast_count", wl_n - lb, 8);
        chk("t3_aw7_addr", aw_addr_a[(ab + 7) % 64], 32'h2380);

        // zero-beat transfer
        snap();
        cfg(32'h1000, 5);
        chk("t4_done_pulse", DONE, 1);
        chk("t4_no_awvalid", bus.M_AXI_AWVALID, 0);
        @(negedge ACLK);
        chk("t4_done_low", DONE, 0);
        repeat (10) @(negedge ACLK);
        chk("t4_aw_count", aw_n - ab, 0);
        chk("t4_done_count", done_n - db, 1);

        // SLVERR on the second of three bursts
        snap();
        err_idx = b_issued + 1;
        cfg(32'h3000, 384);
        wait_done("t5_done", 600);
        chk("t5_aw_count", aw_n - ab, 3);
        chk("t5_error_after_done", ERROR, 1);
        err_idx = -1;
        cfg(32'h4000, 8);
        chk("t5_error_cleared", ERROR, 0);
        wait_done("t5b_done", 200);

        // reset in the middle of a burst
        snap();
        cfg(32'h5000, 1024);
        for (int k = 0; k < 200; k++) begin
            @(negedge ACLK);
            if (w_n - wb >= 5) break;
        end
        chk("t6_mid_burst", (w_n - wb >= 5) ? 1 : 0, 1);
        ARESETN = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (20) @(negedge ACLK);
        chk("t6_no_done", done_n - db, 0);
        snap();
        cfg(32'h6000, 128);
        wait_done("t6_done", 300);
        chk("t6_aw_count", aw_n - ab, 1);
        chk("t6_aw_addr", aw_addr_a[ab % 64], 32'h6000);
        chk("t6_aw_len", aw_len_a[ab % 64], 15);
        chk("t6_w_beats", w_n - wb, 16);

        chk("order_w_before_aw", order_err, 0);
        chk("wlast_placement", wlast_err, 0);
        chk("wdata_stream", data_err, 0);
        chk("outstanding_limit", ovf_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/axi_burst_writer.md
# axi_burst_writer

Parametrised AXI3 write master that streams a `din` valid/ready stream into a contiguous DRAM region described by one config transaction. It splits the transfer into INCR bursts of up to `BURST_BEATS` beats and shortens the first and last bursts so that no burst crosses a burst-size boundary. It limits bursts in flight, tracks write responses, and reports completion and error status. It sits between the camera/pipeline output stream and a Zynq HP port.

## Interface
- `DATA_W`, default 64: data bus width in bits; 64 or 128. `BEAT_BYTES` = `DATA_W`/8.
- `BURST_BEATS`, default 16: maximum beats per burst; power of 2, 1..16.
- `MAX_OUTSTANDING`, default 4: maximum bursts with AW accepted and B not yet received; power of 2, 1..8.
- `ACLK` in 1: clock.
- `ARESETN` in 1: reset, asynchronous, active-low.
- `M_AXI_AWADDR` out 32: burst address.
- `M_AXI_AWLEN` out 4: beats in burst minus 1.
- `M_AXI_AWSIZE` out 3: constant log2(`BEAT_BYTES`).
- `M_AXI_AWBURST` out 2: constant 2'b01 (INCR).
- `M_AXI_AWVALID` out 1, `M_AXI_AWREADY` in 1: AW handshake.
- `M_AXI_WDATA` out `DATA_W`: write data; equals `din`.
- `M_AXI_WSTRB` out `BEAT_BYTES`: constant all ones.
- `M_AXI_WLAST` out 1: final beat of the current burst.
- `M_AXI_WVALID` out 1, `M_AXI_WREADY` in 1: W handshake.
- `M_AXI_BRESP` in 2, `M_AXI_BVALID` in 1: write response.
- `M_AXI_BREADY` out 1: constant 1.
- `CONFIG_VALID` in 1, `CONFIG_READY` out 1: config handshake.
- `CONFIG_START_ADDR` in 32: start address.
- `CONFIG_NBYTES` in 32: transfer length in bytes.
- `din` in `DATA_W`, `din_valid` in 1, `din_ready` out 1: input stream.
- `DONE` out 1: one-cycle pulse when the final B response of a transfer is received.
- `ERROR` out 1: sticky flag; set on any BRESP != 2'b00 during the transfer.

## Operation
- Config is accepted when `CONFIG_VALID && CONFIG_READY`. Both fields are latched on acceptance.
- Address alignment: the low log2(`BEAT_BYTES`) bits of START_ADDR are forced to zero.
- Beat count: beats = NBYTES / `BEAT_BYTES`, truncated. Any byte remainder is ignored.
- Zero beats: the block returns to IDLE and `DONE` pulses on the cycle after acceptance. No AXI traffic is issued.
- Burst length = min(remaining beats, `BURST_BEATS` − (beat address mod `BURST_BEATS`)). The next address advances by length × `BEAT_BYTES`.
- Each AW handshake pushes its length into the W-side length FIFO (depth `MAX_OUTSTANDING`).
- W side:
  - Pops a length and sends exactly that many beats.
  - Sends no beat of a burst before that burst's AW handshake.
  - `M_AXI_WLAST` = 1 on the beat where the per-burst countdown is 0.
- Outstanding counter:
  - Increments on each AW handshake; decrements on each `M_AXI_BVALID`.
  - AW handshake and BVALID in the same cycle leave it unchanged.
  - `M_AXI_AWVALID` is deasserted while the counter equals `MAX_OUTSTANDING`.
- FSM states:
  - IDLE → RUN on config acceptance.
  - RUN → DRAIN once all AW and all W beats have been issued.
  - DRAIN → IDLE when the outstanding counter reaches 0. `DONE` pulses on that transition.
- `CONFIG_READY` = 1 in IDLE only (combinational).
- `ERROR`: cleared on config acceptance; set on any BVALID with BRESP != 0. It remains readable after `DONE`.
- An `ARESETN` assertion mid-transfer abandons the transfer immediately. No `DONE` pulse is produced, and all counters and the FIFO clear.

## Timing
- Reset values:
  - `M_AXI_AWVALID`, `M_AXI_WVALID`, `M_AXI_WLAST`, `DONE`, `ERROR`, `din_ready` = 0.
  - `M_AXI_AWADDR` = 0.
  - `M_AXI_AWLEN` = 0.
  - `CONFIG_READY` = 1.
  - Constant outputs hold their constants.
- First `M_AXI_AWVALID` is asserted on the cycle after config acceptance. Back-to-back AW bursts are possible (one per cycle).
- `M_AXI_AWADDR` and `M_AXI_AWLEN` stay stable while `M_AXI_AWVALID` && !`M_AXI_AWREADY`.
- W signals are combinational:
  - `M_AXI_WVALID` = w_active && `din_valid`.
  - `din_ready` = w_active && `M_AXI_WREADY`.
  - w_active = burst popped and beats remaining.
- Bursts are back-to-back with no bubble when the next length is already in the FIFO.
- `DONE` pulses for exactly one cycle. The next config can be accepted on the following cycle.

## Structure
- Package `axi_writer_pkg`:
  - FSM state enum (IDLE, RUN, DRAIN).
  - Constants AXI_BURST_INCR = 2'b01 and RESP_OKAY = 2'b00.
  - Function size_enc(bytes).
- Sub-module `burst_len_fifo`: synchronous FIFO, width 4, depth `MAX_OUTSTANDING`, with full/empty outputs.

## Test plan
- DATA_W=64, START=0x1000, NBYTES=256, always-ready slave → 2 AW (0x1000 and 0x1080, AWLEN=15), 32 W beats, WLAST on beats 16 and 32, one `DONE` pulse.
- START=0x1030, NBYTES=200 → 25 beats split 10 (AWLEN=9 at 0x1030) + 15 (AWLEN=14 at 0x1080), `DONE` after 2 B.
- MAX_OUTSTANDING=2, BVALID withheld, NBYTES=1024 → exactly 2 AW issued, AWVALID low until the first B, 8 bursts total.
- NBYTES=5 → no AWVALID, `DONE` pulses on the cycle after acceptance.
- BRESP=2'b10 on the second of 3 bursts → `ERROR`=1 at `DONE`, cleared on the next config acceptance.
- Reset asserted mid-burst → all outputs at reset values, `CONFIG_READY`=1, no `DONE`; a new 128-byte transfer then completes normally.
